// File: rtl/rv4028_bus_pkg.sv
// Shared types for the RV4028 8-bit SRAM bridge: controller FSM states and the posted-write entry.
package rv4028_bus_pkg;

    // Halfword address as seen on the bus (addr[31:1]); the top slices off what the SRAM needs.
    localparam int BUS_HW_ADDR_W = 31;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_LO   = 3'd1,
        ST_WR_HI   = 3'd2,
        ST_WR_GAP  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RD_LO   = 3'd5,
        ST_RD_HI   = 3'd6,
        ST_RD_DONE = 3'd7
    } state_t;

    typedef struct packed {
        logic [BUS_HW_ADDR_W-1:0] addr;
        logic [1:0]               mask;   // active-low byte lanes, [0] = data[7:0]
        logic [15:0]              data;
    } wr_entry_t;

endpackage

// File: rtl/rv4028_wr_fifo.sv
// Synchronous FIFO with registered push/pop; head is visible on pop_dat while not empty.
// Latency: a push is visible one cycle later; push while full is dropped, pop while empty is ignored.
module rv4028_wr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rv4028_sram8_ctrl.sv
// RV4028 memory-space target: posted halfword writes and stalled halfword reads over an 8-bit async SRAM.
// Latency: reads hold wait_n low 2*RD_CYCLES cycles plus any write drain; writes never stall and overflow is sticky.
module rv4028_sram8_ctrl
    import rv4028_bus_pkg::*;
#(
    parameter int ADDR_W     = 19,
    parameter int RD_CYCLES  = 2,
    parameter int WR_CYCLES  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       addr,
    input  logic              rd_n,
    input  logic [1:0]        wr_n,
    input  logic [1:0]        msk_n,
    input  logic              iorq_n,
    input  logic [15:0]       data_in,
    output logic              wait_n,
    output logic [15:0]       rdata,
    output logic              rdata_oe,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_out,
    input  logic [7:0]        sram_dq_in,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              wr_overflow
);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

    state_t state;
    state_t state_nxt;
    state_t first_lane;
    logic [CNT_W-1:0] cnt;
    logic             byte_hi;

    logic                     cmd_vld;
    logic [BUS_HW_ADDR_W-1:0] cmd_addr;
    logic [1:0]               cmd_msk;
    wr_entry_t                push_ent;
    wr_entry_t                head;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;

    logic              rd_phase;
    logic              rd_pend;
    logic [ADDR_W-2:0] rd_addr;
    logic [7:0]        rd_lo;
    logic              rd_start;
    logic              rd_end;
    logic              rd_go;

    // Command edge latches address/mask; the following edge pushes with that cycle's data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_vld     <= 1'b0;
            cmd_addr    <= '0;
            cmd_msk     <= 2'b11;
            wr_overflow <= 1'b0;
        end else if (cmd_vld) begin
            cmd_vld <= 1'b0;
            if (fifo_full) wr_overflow <= 1'b1;
        end else if (iorq_n && (wr_n == 2'b00)) begin
            cmd_vld  <= 1'b1;
            cmd_addr <= addr[31:1];
            cmd_msk  <= msk_n;
        end
    end

    assign push_ent = {cmd_addr, cmd_msk, data_in};

    rv4028_wr_fifo #(
        .WIDTH ($bits(wr_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (cmd_vld),
        .push_dat (push_ent),
        .pop      (fifo_pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // rd_end covers both the CPU sampling edge (wait_n already high) and an abort (rd_n released).
    assign rd_start = !rd_n && !rd_phase && iorq_n;
    assign rd_end   = rd_phase && (rd_n || wait_n);
    assign rd_go    = rd_start || (rd_pend && !rd_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_phase <= 1'b0;
            rd_pend  <= 1'b0;
            rd_addr  <= '0;
            rd_lo    <= '0;
            rdata    <= '0;
            rdata_oe <= 1'b0;
            wait_n   <= 1'b1;
        end else if (rd_start) begin
            rd_phase <= 1'b1;
            rd_pend  <= (state_nxt != ST_RD_LO);
            rd_addr  <= addr[ADDR_W-1:1];
            wait_n   <= 1'b0;
            rdata_oe <= 1'b1;
        end else if (rd_end) begin
            rd_phase <= 1'b0;
            rd_pend  <= 1'b0;
            wait_n   <= 1'b1;
            rdata_oe <= 1'b0;
        end else begin
            if (state_nxt == ST_RD_LO) rd_pend <= 1'b0;
            if ((state == ST_RD_LO) && (cnt == RD_LAST)) rd_lo <= sram_dq_in;
            if ((state == ST_RD_HI) && (cnt == RD_LAST)) begin
                rdata  <= {sram_dq_in, rd_lo};
                wait_n <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            byte_hi <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
            if (state_nxt == ST_WR_HI)      byte_hi <= 1'b1;
            else if (state_nxt == ST_WR_LO) byte_hi <= 1'b0;
        end
    end

    always_comb begin
        first_lane = head.mask[0] ? ST_WR_HI : ST_WR_LO;
        state_nxt  = state;
        fifo_pop   = 1'b0;
        case (state)
            ST_IDLE, ST_RD_WAIT: begin
                // Drain writes first; an entry with both lanes masked is simply discarded.
                if (!fifo_empty) begin
                    if (head.mask == 2'b11) fifo_pop  = 1'b1;
                    else                    state_nxt = first_lane;
                end else if (rd_go) begin
                    state_nxt = ST_RD_LO;
                end
            end
            ST_WR_LO, ST_WR_HI: begin
                if (cnt == WR_LAST) state_nxt = ST_WR_GAP;
            end
            ST_WR_GAP: begin
                if (!byte_hi && !head.mask[1]) begin
                    state_nxt = ST_WR_HI;
                end else begin
                    fifo_pop  = 1'b1;
                    state_nxt = rd_go ? ST_RD_WAIT : ST_IDLE;
                end
            end
            ST_RD_LO: begin
                if (cnt == RD_LAST) state_nxt = ST_RD_HI;
            end
            ST_RD_HI: begin
                if (cnt == RD_LAST) state_nxt = ST_RD_DONE;
            end
            ST_RD_DONE: begin
                if (rd_end || !rd_phase) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (rd_end && (state inside {ST_RD_WAIT, ST_RD_LO, ST_RD_HI})) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_ce_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_we_n   = 1'b1;
        case (state)
            ST_WR_LO, ST_WR_HI, ST_WR_GAP: begin
                sram_ce_n   = 1'b0;
                sram_we_n   = (state == ST_WR_GAP);
                sram_dq_oe  = 1'b1;
                sram_addr   = {head.addr[ADDR_W-2:0], byte_hi};
                sram_dq_out = byte_hi ? head.data[15:8] : head.data[7:0];
            end
            ST_RD_LO, ST_RD_HI: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_addr = {rd_addr, (state == ST_RD_HI)};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rv4028_sram8_ctrl.sv
// Directed bench: default-timing instance plus a WR_CYCLES=8 instance used only for the overflow scenario.
module tb_rv4028_sram8_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        rd_n;
    logic [1:0]  wr_n;
    logic [1:0]  msk_n;
    logic        iorq_n;
    logic        iorq_n_s;
    logic [15:0] data_in;

    logic        wait_n, rdata_oe, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, wr_overflow;
    logic [15:0] rdata;
    logic [18:0] sram_addr;
    logic [7:0]  sram_dq_out, sram_dq_in;

    logic        s_wait_n, s_rdata_oe, s_sram_dq_oe, s_sram_ce_n, s_sram_oe_n, s_sram_we_n, s_wr_overflow;
    logic [15:0] s_rdata;
    logic [18:0] s_sram_addr;
    logic [7:0]  s_sram_dq_out, s_sram_dq_in;

    logic [7:0] mem_f [0:4095];
    logic [7:0] mem_s [0:4095];

    int chk_cnt;
    int pass_cnt;

    rv4028_sram8_ctrl dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rd_n(rd_n), .wr_n(wr_n), .msk_n(msk_n),
        .iorq_n(iorq_n), .data_in(data_in), .wait_n(wait_n), .rdata(rdata), .rdata_oe(rdata_oe),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .wr_overflow(wr_overflow)
    );

    rv4028_sram8_ctrl #(.WR_CYCLES(8)) dut_slow (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rd_n(rd_n), .wr_n(wr_n), .msk_n(msk_n),
        .iorq_n(iorq_n_s), .data_in(data_in), .wait_n(s_wait_n), .rdata(s_rdata), .rdata_oe(s_rdata_oe),
        .sram_addr(s_sram_addr), .sram_dq_out(s_sram_dq_out), .sram_dq_in(s_sram_dq_in),
        .sram_dq_oe(s_sram_dq_oe), .sram_ce_n(s_sram_ce_n), .sram_oe_n(s_sram_oe_n),
        .sram_we_n(s_sram_we_n), .wr_overflow(s_wr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Async SRAM models: write on the rising edge of we_n, read while oe_n is low.
    assign sram_dq_in   = !sram_oe_n   ? mem_f[sram_addr[11:0]]   : 8'h00;
    assign s_sram_dq_in = !s_sram_oe_n ? mem_s[s_sram_addr[11:0]] : 8'h00;
    always @(posedge sram_we_n)   if (!sram_ce_n)   mem_f[sram_addr[11:0]]   <= sram_dq_out;
    always @(posedge s_sram_we_n) if (!s_sram_ce_n) mem_s[s_sram_addr[11:0]] <= s_sram_dq_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [15:0] d, input logic [1:0] m);
        addr = a; msk_n = m; wr_n = 2'b00; data_in = 16'h0000;
        tick();
        wr_n = 2'b11; data_in = d;
        tick();
        data_in = 16'h0000; msk_n = 2'b11;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [15:0] d, output int lows,
                           output logic oe_at, output logic oe_after);
        addr = a; rd_n = 1'b0; lows = 0;
        tick();
        while (wait_n === 1'b0 && lows < 200) begin
            lows++;
            tick();
        end
        d = rdata; oe_at = rdata_oe;
        tick();
        oe_after = rdata_oe;
        rd_n = 1'b1;
    endtask

    task automatic test_reset();
        chk_cnt++; if (wait_n !== 1'b1) $display("FAIL rst_wait_n got=%0h exp=1", wait_n); else pass_cnt++;
        chk_cnt++; if (rdata !== 16'h0000) $display("FAIL rst_rdata got=%h exp=0000", rdata); else pass_cnt++;
        chk_cnt++; if (rdata_oe !== 1'b0) $display("FAIL rst_rdata_oe got=%0h exp=0", rdata_oe); else pass_cnt++;
        chk_cnt++; if (sram_addr !== 19'h0) $display("FAIL rst_sram_addr got=%h exp=0", sram_addr); else pass_cnt++;
        chk_cnt++; if ({sram_dq_oe, sram_dq_out} !== 9'h000) $display("FAIL rst_dq got=%h exp=000", {sram_dq_oe, sram_dq_out}); else pass_cnt++;
        chk_cnt++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) $display("FAIL rst_strobes got=%b exp=111", {sram_ce_n, sram_oe_n, sram_we_n}); else pass_cnt++;
        chk_cnt++; if (wr_overflow !== 1'b0) $display("FAIL rst_overflow got=%0h exp=0", wr_overflow); else pass_cnt++;
    endtask

    task automatic test_write_full();
        int   we_low;
        int   we_runs;
        logic prev_we;
        logic wait_ok;
        do_write(32'h100, 16'hBEEF, 2'b00);
        we_low = 0; we_runs = 0; prev_we = 1'b1; wait_ok = 1'b1;
        repeat (12) begin
            if (!sram_we_n) begin
                we_low++;
                if (prev_we) we_runs++;
            end
            prev_we = sram_we_n;
            if (wait_n !== 1'b1) wait_ok = 1'b0;
            tick();
        end
        chk_cnt++; if (mem_f[12'h100] !== 8'hEF) $display("FAIL wr_byte_100 got=%h exp=ef", mem_f[12'h100]); else pass_cnt++;
        chk_cnt++; if (mem_f[12'h101] !== 8'hBE) $display("FAIL wr_byte_101 got=%h exp=be", mem_f[12'h101]); else pass_cnt++;
        chk_cnt++; if (we_low !== 2) $display("FAIL wr_we_low_cycles got=%0d exp=2", we_low); else pass_cnt++;
        chk_cnt++; if (we_runs !== 2) $display("FAIL wr_we_pulses got=%0d exp=2", we_runs); else pass_cnt++;
        chk_cnt++; if (wait_ok !== 1'b1) $display("FAIL wr_wait_n got=0 exp=1"); else pass_cnt++;
    endtask

    task automatic test_read_basic();
        logic [15:0] d;
        int          lows;
        logic        oe_at, oe_after;
        do_read(32'h100, d, lows, oe_at, oe_after);
        chk_cnt++; if (lows !== 4) $display("FAIL rd_wait_low got=%0d exp=4", lows); else pass_cnt++;
        chk_cnt++; if (d !== 16'hBEEF) $display("FAIL rd_data got=%h exp=beef", d); else pass_cnt++;
        chk_cnt++; if (oe_at !== 1'b1) $display("FAIL rd_oe_at_done got=%0h exp=1", oe_at); else pass_cnt++;
        chk_cnt++; if (oe_after !== 1'b0) $display("FAIL rd_oe_after got=%0h exp=0", oe_after); else pass_cnt++;
    endtask

    task automatic test_masked_write();
        int we_low;
        do_write(32'h200, 16'h1234, 2'b10);
        we_low = 0;
        repeat (12) begin
            if (!sram_we_n) we_low++;
            tick();
        end
        chk_cnt++; if (mem_f[12'h200] !== 8'h34) $display("FAIL msk_byte_200 got=%h exp=34", mem_f[12'h200]); else pass_cnt++;
        chk_cnt++; if (mem_f[12'h201] !== 8'h5B) $display("FAIL msk_byte_201 got=%h exp=5b", mem_f[12'h201]); else pass_cnt++;
        chk_cnt++; if (we_low !== 1) $display("FAIL msk_we_low_cycles got=%0d exp=1", we_low); else pass_cnt++;
    endtask

    task automatic test_store_then_read();
        logic [15:0] d;
        int          lows;
        logic        oe_at, oe_after;
        do_write(32'h300, 16'hCAFE, 2'b00);
        do_write(32'h302, 16'hF00D, 2'b00);
        do_read(32'h300, d, lows, oe_at, oe_after);
        chk_cnt++; if (d !== 16'hCAFE) $display("FAIL st_rd_data got=%h exp=cafe", d); else pass_cnt++;
        chk_cnt++; if (lows <= 4 || lows > 16) $display("FAIL st_rd_wait_low got=%0d exp=5..16", lows); else pass_cnt++;
        chk_cnt++; if ({mem_f[12'h303], mem_f[12'h302]} !== 16'hF00D) $display("FAIL st_drained got=%h exp=f00d", {mem_f[12'h303], mem_f[12'h302]}); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] d0, d1;
        int          l0, l1;
        logic        a0, a1, b0, b1;
        do_read(32'h300, d0, l0, a0, b0);
        do_read(32'h302, d1, l1, a1, b1);
        chk_cnt++; if (d0 !== 16'hCAFE || l0 !== 4) $display("FAIL b2b_first got=%h/%0d exp=cafe/4", d0, l0); else pass_cnt++;
        chk_cnt++; if (d1 !== 16'hF00D || l1 !== 4) $display("FAIL b2b_second got=%h/%0d exp=f00d/4", d1, l1); else pass_cnt++;
    endtask

    task automatic test_overflow();
        iorq_n = 1'b0; iorq_n_s = 1'b1;
        for (int k = 0; k < 5; k++) begin
            do_write(32'h400 + 32'(2 * k), {8'hA0 + 8'(k), 8'h50 + 8'(k)}, 2'b00);
            if (k == 3) begin
                chk_cnt++; if (s_wr_overflow !== 1'b0) $display("FAIL ovf_after4 got=%0h exp=0", s_wr_overflow); else pass_cnt++;
            end
        end
        chk_cnt++; if (s_wr_overflow !== 1'b1) $display("FAIL ovf_after5 got=%0h exp=1", s_wr_overflow); else pass_cnt++;
        repeat (120) tick();
        chk_cnt++; if ({mem_s[12'h401], mem_s[12'h400]} !== 16'hA050) $display("FAIL ovf_e0 got=%h exp=a050", {mem_s[12'h401], mem_s[12'h400]}); else pass_cnt++;
        chk_cnt++; if ({mem_s[12'h403], mem_s[12'h402]} !== 16'hA151) $display("FAIL ovf_e1 got=%h exp=a151", {mem_s[12'h403], mem_s[12'h402]}); else pass_cnt++;
        chk_cnt++; if ({mem_s[12'h405], mem_s[12'h404]} !== 16'hA252) $display("FAIL ovf_e2 got=%h exp=a252", {mem_s[12'h405], mem_s[12'h404]}); else pass_cnt++;
        chk_cnt++; if ({mem_s[12'h407], mem_s[12'h406]} !== 16'hA353) $display("FAIL ovf_e3 got=%h exp=a353", {mem_s[12'h407], mem_s[12'h406]}); else pass_cnt++;
        chk_cnt++; if ({mem_s[12'h409], mem_s[12'h408]} !== 16'h5352) $display("FAIL ovf_dropped got=%h exp=5352", {mem_s[12'h409], mem_s[12'h408]}); else pass_cnt++;
        chk_cnt++; if (mem_f[12'h400] !== 8'h5A) $display("FAIL ovf_io_ignored got=%h exp=5a", mem_f[12'h400]); else pass_cnt++;
        iorq_n = 1'b1; iorq_n_s = 1'b0;
    endtask

    task automatic test_iorq_ignored();
        int bad_wait, bad_oe, bad_ce;
        bad_wait = 0; bad_oe = 0; bad_ce = 0;
        iorq_n = 1'b0; addr = 32'h100; rd_n = 1'b0;
        repeat (6) begin
            tick();
            if (wait_n !== 1'b1)   bad_wait++;
            if (rdata_oe !== 1'b0) bad_oe++;
            if (sram_ce_n !== 1'b1) bad_ce++;
        end
        rd_n = 1'b1;
        do_write(32'h100, 16'h1111, 2'b00);
        repeat (8) begin
            if (sram_ce_n !== 1'b1) bad_ce++;
            tick();
        end
        iorq_n = 1'b1;
        chk_cnt++; if (bad_wait !== 0) $display("FAIL io_wait_n got=%0d low cycles exp=0", bad_wait); else pass_cnt++;
        chk_cnt++; if (bad_oe !== 0) $display("FAIL io_rdata_oe got=%0d cycles exp=0", bad_oe); else pass_cnt++;
        chk_cnt++; if (bad_ce !== 0) $display("FAIL io_ce_n got=%0d strobe cycles exp=0", bad_ce); else pass_cnt++;
        chk_cnt++; if (mem_f[12'h100] !== 8'hEF) $display("FAIL io_mem got=%h exp=ef", mem_f[12'h100]); else pass_cnt++;
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] d;
        int          lows;
        logic        oe_at, oe_after;
        addr = 32'h100; rd_n = 1'b0;
        tick();
        chk_cnt++; if (sram_oe_n !== 1'b0) $display("FAIL mr_in_rd_lo got=%0h exp=0", sram_oe_n); else pass_cnt++;
        tick();
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (wait_n !== 1'b1) $display("FAIL mr_wait_n got=%0h exp=1", wait_n); else pass_cnt++;
        chk_cnt++; if ({rdata_oe, rdata} !== 17'h0) $display("FAIL mr_rdata got=%h exp=00000", {rdata_oe, rdata}); else pass_cnt++;
        chk_cnt++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) $display("FAIL mr_strobes got=%b exp=111", {sram_ce_n, sram_oe_n, sram_we_n}); else pass_cnt++;
        chk_cnt++; if (sram_addr !== 19'h0) $display("FAIL mr_sram_addr got=%h exp=0", sram_addr); else pass_cnt++;
        rd_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        do_read(32'h100, d, lows, oe_at, oe_after);
        chk_cnt++; if (d !== 16'hBEEF || lows !== 4) $display("FAIL mr_next_read got=%h/%0d exp=beef/4", d, lows); else pass_cnt++;
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0;
        rst_n = 1'b0; addr = '0; rd_n = 1'b1; wr_n = 2'b11; msk_n = 2'b11;
        iorq_n = 1'b1; iorq_n_s = 1'b0; data_in = '0;
        for (int i = 0; i < 4096; i++) begin
            mem_f[i] = 8'(i) ^ 8'h5A;
            mem_s[i] = 8'(i) ^ 8'h5A;
        end
        #12;
        test_reset();
        #1 rst_n = 1'b1;
        tick();
        test_write_full();
        test_read_basic();
        test_masked_write();
        test_store_then_read();
        test_back_to_back();
        test_overflow();
        test_iorq_ignored();
        test_reset_mid_read();
        chk_cnt++; if (wr_overflow !== 1'b0) $display("FAIL fast_overflow got=%0h exp=0", wr_overflow); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
